node_turn_executor: RTL
=======================

// Module: node_turn_executor
// PURPOSE
// - Motion stage around path_mapping: detects nodes from the 3 line sensors, pulses node_flag/node_changed
//   into path_mapping, samples turn_flag after the planning latency, and drives the wheel-direction codes
//   through straight/right/U/left manoeuvres, then resumes line following.
// - Sits between the sensor thresholding block and the motor PWM driver.
// PARAMETERS
// - NODE_DEB     4      consecutive cycles all sensors high to declare a node
// - PLAN_WAIT    16     cycles from node_changed pulse to turn_flag sample (path_mapping needs <=7)
// - CLEAR_CYC    3125   forward cycles after sample to centre axle on node (1 ms @3.125 MHz)
// - TURN_MIN     1563   minimum spin cycles before line re-acquire is accepted
// - TURN_TIMEOUT 31250  spin cycle limit per line acquisition (WATCHDOG_EN only)
// PORTS
// - clk_3125KHz   in   1  system clock
// - reset         in   1  asynchronous, active-high reset
// - start         in   1  level; 1 = run, 0 = return to IDLE at next FOLLOW cycle
// - line_l/c/r    in   1  thresholded sensors, 1 = on black line
// - turn_flag     in   2  from path_mapping: 0 straight, 1 right, 2 U-turn, 3 left
// - node_flag     out  1  1-cycle pulse on node declaration
// - node_changed  out  1  1-cycle pulse, cycle after node_flag
// - mtr_l, mtr_r  out  2  wheel code: 00 stop, 01 fwd, 10 rev (11 never driven)
// - busy          out  1  high in any state except IDLE/FAULT
// - fault         out  1  sticky until reset (WATCHDOG_EN only, else tied 0)
// BEHAVIOUR
// - Reset: state IDLE, all outputs 0, counters 0, turn register 0; async assert, sync-safe release.
// - All outputs registered. States: IDLE, FOLLOW, NODE, REQ, PLAN, CLEAR, SPIN_OUT, SPIN_IN, FAULT.
// - IDLE: motors stop; start=1 -> FOLLOW.
// - FOLLOW: c-only or l+c+r partial -> both fwd; l=1,r=0 -> mtr_l=00,mtr_r=01; r=1,l=0 -> mtr_l=01,mtr_r=00;
//   none high -> hold previous codes. Debounce counter counts all-high cycles, clears on any low;
//   reaching NODE_DEB -> NODE. start=0 -> IDLE (takes priority over node declaration same cycle).
// - NODE: node_flag=1 one cycle, motors stop -> REQ. REQ: node_changed=1 one cycle -> PLAN.
// - PLAN: motors stop, count PLAN_WAIT; on terminal cycle latch turn_flag -> CLEAR.
// - CLEAR: both fwd CLEAR_CYC cycles; then turn 0 -> FOLLOW, else -> SPIN_OUT with laps=1 (2 for U).
// - Spin direction: right/U: mtr_l=01,mtr_r=10; left: mtr_l=10,mtr_r=01.
// - SPIN_OUT: spin until line_c=0 AND count>=TURN_MIN -> SPIN_IN.
// - SPIN_IN: spin until line_c=1 -> laps-1; laps reaches 0 -> FOLLOW with debounce cleared, else SPIN_OUT.
// - Node re-arm: after leaving CLEAR/SPIN_IN, a new node is only declared after >=1 cycle of not-all-high.
// - Counters saturate, never wrap; sized by $clog2 of largest parameter.
// - turn_flag changes outside the PLAN terminal cycle are ignored; reset mid-manoeuvre -> IDLE, motors stop.
// CONFIGURATION
// - TURN_WATCHDOG_EN defined: per-acquisition spin counter; reaching TURN_TIMEOUT in SPIN_OUT or SPIN_IN
//   -> FAULT: motors 00, fault=1, busy=0, exits only by reset; start ignored.
// - Not defined: spins wait indefinitely for sensor edges; FAULT unreachable; fault tied 0.
// TESTING
// - Reset during SPIN_IN with mtr=01/10 -> next edge outputs 00/00, busy=0, no pulses.
// - start=1, line_c only for 100 cyc -> mtr_l=mtr_r=01, node_flag never pulses.
// - l/c/r all high 3 cyc then low -> no node; 4 cyc -> node_flag at cycle 5, node_changed next cycle.
// - Node, turn_flag=0 at sample -> stop 16 cyc, fwd 3125 cyc, back to FOLLOW, no spin.
// - turn_flag=3, line_c drops at cyc 500, returns at 2000 -> spin 10/01 until cyc>=1563 and c=0, exit on c=1.
// - turn_flag=2 -> two off/on line_c laps required, right-spin codes throughout.
// - TURN_WATCHDOG_EN, turn=1, line_c held 1 -> fault=1 after 31250 spin cycles, motors 00.

Source files
------------

// File: rtl/node_turn_executor.sv
// node_turn_executor: node detection, path_mapping handshake and turn manoeuvres for the line follower.
// Optional TURN_WATCHDOG_EN: spin timeout that latches a sticky fault.
module node_turn_executor #(
    parameter int NODE_DEB     = 4,
    parameter int PLAN_WAIT    = 16,
    parameter int CLEAR_CYC    = 3125,
    parameter int TURN_MIN     = 1563,
    parameter int TURN_TIMEOUT = 31250
) (
    input  logic       clk_3125KHz,
    input  logic       reset,
    input  logic       start,
    input  logic       line_l,
    input  logic       line_c,
    input  logic       line_r,
    input  logic [1:0] turn_flag,
    output logic       node_flag,
    output logic       node_changed,
    output logic [1:0] mtr_l,
    output logic [1:0] mtr_r,
    output logic       busy,
    output logic       fault
);
    localparam int W  = $clog2(TURN_TIMEOUT + 1);
    localparam int DW = $clog2(NODE_DEB + 1);
    localparam logic [W-1:0]  PLAN_END  = W'(PLAN_WAIT - 1);
    localparam logic [W-1:0]  CLEAR_END = W'(CLEAR_CYC - 1);
    localparam logic [W-1:0]  SPIN_MIN  = W'(TURN_MIN);
    localparam logic [DW-1:0] DEB_END   = DW'(NODE_DEB - 1);
`ifdef TURN_WATCHDOG_EN
    localparam logic [W-1:0]  TO_END    = W'(TURN_TIMEOUT - 1);
`endif
    localparam logic [3:0] IDLE = 4'd0, FOLLOW = 4'd1, NODE = 4'd2, REQ = 4'd3, PLAN = 4'd4,
                           CLEAR = 4'd5, SPIN_OUT = 4'd6, SPIN_IN = 4'd7, FAULT = 4'd8;
    logic [1:0] rst_sync;
    logic rst;
    logic [3:0] state, state_n;
    logic [W-1:0] cnt, cnt_n, cnt_inc;
    logic [DW-1:0] deb, deb_n, deb_inc;
    logic armed, armed_n, node_flag_n, node_changed_n, fault_n, all_hi;
    logic [1:0] turn, turn_n, laps, laps_n, mtr_l_n, mtr_r_n;
    // Reset asserts immediately, releases on a clock edge
    always_ff @(posedge clk_3125KHz or posedge reset)
        if (reset) rst_sync <= 2'b11;
        else rst_sync <= {rst_sync[0], 1'b0};
    assign rst = rst_sync[1];
    assign all_hi = line_l & line_c & line_r;
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign deb_inc = (&deb) ? deb : deb + 1'b1;
    always_comb begin
        state_n = state;
        cnt_n = cnt_inc;
        deb_n = deb;
        armed_n = armed;
        turn_n = turn;
        laps_n = laps;
        mtr_l_n = mtr_l;
        mtr_r_n = mtr_r;
        node_flag_n = 1'b0;
        node_changed_n = 1'b0;
        fault_n = fault;
        case (state)
            IDLE: begin
                mtr_l_n = 2'b00;
                mtr_r_n = 2'b00;
                deb_n = '0;
                cnt_n = '0;
                armed_n = 1'b1;
                if (start) state_n = FOLLOW;
            end
            FOLLOW: begin
                if (!start) begin
                    state_n = IDLE;
                    mtr_l_n = 2'b00;
                    mtr_r_n = 2'b00;
                    deb_n = '0;
                end else begin
                    mtr_l_n = (line_l ^ line_r) ? {1'b0, line_r} : (line_l | line_c | line_r) ? 2'b01 : mtr_l;
                    mtr_r_n = (line_l ^ line_r) ? {1'b0, line_l} : (line_l | line_c | line_r) ? 2'b01 : mtr_r;
                    armed_n = armed | ~all_hi;
                    deb_n = (all_hi && armed) ? deb_inc : '0;
                    if (all_hi && armed && deb == DEB_END) begin
                        state_n = NODE;
                        node_flag_n = 1'b1;
                        mtr_l_n = 2'b00;
                        mtr_r_n = 2'b00;
                        deb_n = '0;
                    end
                end
            end
            NODE: begin
                state_n = REQ;
                node_changed_n = 1'b1;
                cnt_n = '0;
            end
            REQ: state_n = PLAN;
            PLAN: if (cnt == PLAN_END) begin
                turn_n = turn_flag;
                state_n = CLEAR;
                cnt_n = '0;
                mtr_l_n = 2'b01;
                mtr_r_n = 2'b01;
            end
            CLEAR: if (cnt == CLEAR_END) begin
                cnt_n = '0;
                if (turn == 2'd0) begin
                    state_n = FOLLOW;
                    armed_n = 1'b0;
                    deb_n = '0;
                end else begin
                    state_n = SPIN_OUT;
                    laps_n = (turn == 2'd2) ? 2'd2 : 2'd1;
                    mtr_l_n = (turn == 2'd3) ? 2'b10 : 2'b01;
                    mtr_r_n = (turn == 2'd3) ? 2'b01 : 2'b10;
                end
            end
            SPIN_OUT: if (!line_c && cnt >= SPIN_MIN) begin
                state_n = SPIN_IN;
                cnt_n = '0;
            end
            SPIN_IN: if (line_c) begin
                cnt_n = '0;
                laps_n = laps - 2'd1;
                state_n = (laps == 2'd1) ? FOLLOW : SPIN_OUT;
                if (laps == 2'd1) begin
                    armed_n = 1'b0;
                    deb_n = '0;
                    mtr_l_n = 2'b01;
                    mtr_r_n = 2'b01;
                end
            end
            FAULT: cnt_n = cnt;
            default: state_n = IDLE;
        endcase
`ifdef TURN_WATCHDOG_EN
        if ((state == SPIN_OUT || state == SPIN_IN) && cnt == TO_END) begin
            state_n = FAULT;
            mtr_l_n = 2'b00;
            mtr_r_n = 2'b00;
            fault_n = 1'b1;
        end
`endif
    end
    always_ff @(posedge clk_3125KHz or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            deb <= '0;
            armed <= 1'b0;
            turn <= 2'd0;
            laps <= 2'd0;
            mtr_l <= 2'b00;
            mtr_r <= 2'b00;
            node_flag <= 1'b0;
            node_changed <= 1'b0;
            busy <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            deb <= deb_n;
            armed <= armed_n;
            turn <= turn_n;
            laps <= laps_n;
            mtr_l <= mtr_l_n;
            mtr_r <= mtr_r_n;
            node_flag <= node_flag_n;
            node_changed <= node_changed_n;
            busy <= (state_n != IDLE) && (state_n != FAULT);
            fault <= fault_n;
        end
endmodule
